// File: rtl/ifexp_pkg.sv
// ifexp_pkg: shared types, defaults and select arithmetic for ifexp_operand_pipe.
// Define IFEXP_SAT_EN to make the B+1 branch saturate instead of wrap.
package ifexp_pkg;

    localparam int AW_DEF = 8;
    localparam int BW_DEF = 16;
    localparam int SELW   = 64;

    function automatic int max_of(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    typedef struct packed {
        logic [AW_DEF-1:0] a;
        logic [BW_DEF-1:0] b;
    } operand_t;

    // Operands arrive zero-extended to SELW; w is the live result width.
    function automatic logic [SELW-1:0] ifexp_sel(
        input logic [SELW-1:0] a_ext,
        input logic [SELW-1:0] b_ext,
        input int              w
    );
        logic [SELW-1:0] mask;
        mask = (SELW'(1) << w) - SELW'(1);
        if (a_ext > b_ext) begin
            return a_ext;
        end
`ifdef IFEXP_SAT_EN
        if (b_ext == mask) begin
            return b_ext;
        end
`endif
        return (b_ext + SELW'(1)) & mask;
    endfunction

endpackage

// File: rtl/ifexp_fifo.sv
// ifexp_fifo: synchronous FIFO with a separate occupancy counter.
// Read data is taken combinationally from the head entry.
module ifexp_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage write; stale contents are harmless once pointers reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap modulo DEPTH; occupancy tracks full/empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifexp_operand_pipe.sv
// ifexp_operand_pipe: FIFO-buffered IfExp select with a registered output.
// Define IFEXP_SAT_EN to saturate the B+1 branch at all ones.
module ifexp_operand_pipe
    import ifexp_pkg::*;
#(
    parameter int AW    = AW_DEF,
    parameter int BW    = BW_DEF,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16,
    localparam int W    = max_of(AW, BW)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [AW-1:0]   A,
    input  logic [BW-1:0]   B,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [W-1:0]    XOUT,
    output logic [CNTW-1:0] RES_CNT
);

    typedef struct packed {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
    } pair_t;

    pair_t         wr_pair;
    pair_t         rd_pair;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [W-1:0]  sel_res;

    assign IN_READY  = !full;
    assign push      = IN_VALID && !full;
    assign pop       = !empty && (!OUT_VALID || OUT_READY);
    assign wr_pair.a = A;
    assign wr_pair.b = B;
    assign sel_res   = W'(ifexp_sel(SELW'(rd_pair.a), SELW'(rd_pair.b), W));

    ifexp_fifo #(
        .DW    (AW + BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pair),
        .rdata (rd_pair),
        .full  (full),
        .empty (empty)
    );

    // Output register: load on pop, drop valid when drained and empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID <= 1'b0;
            XOUT      <= '0;
        end else if (pop) begin
            OUT_VALID <= 1'b1;
            XOUT      <= sel_res;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

    // Delivered-result counter, wraps naturally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RES_CNT <= '0;
        end else if (OUT_VALID && OUT_READY) begin
            RES_CNT <= RES_CNT + CNTW'(1);
        end
    end

endmodule
